// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and sizing helpers for the sipo_deser block
//
// Purpose: FSM state type, parity-feature switch, bit-counter width and
//          frame-length helpers used by sipo_deser and sipo_out_buf.
// Ports:   none (package).
// Config:  SIPO_DESER_PARITY_CHK_EN adds an even-parity bit to every frame.
package sipo_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

`ifdef SIPO_DESER_PARITY_CHK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // bit_cnt must be able to represent 0..N
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // serial bits per frame: data bits plus the optional parity bit
  function automatic int frame_len(input int n);
    return PARITY_EN ? n + 1 : n;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// rtl/sipo_out_buf.sv - one-entry valid/ready holding register with sticky overrun
//
// Purpose: captures a completed word on load when empty or being drained,
//          otherwise drops it and sets the sticky overrun flag.
// Ports:   clk, rst (async active-low)
//          load, load_data[N-1:0], load_perr   - completed word from collector
//          ready                               - consumer accept
//          clr_overrun                         - synchronous overrun clear
//          data[N-1:0], valid, perr, overrun   - buffer state
//          accept                              - load taken this cycle
module sipo_out_buf #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         load_perr,
  input  logic         ready,
  input  logic         clr_overrun,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         perr,
  output logic         overrun,
  output logic         accept
);

  logic drop;

  // a full buffer can still take a new word if it is drained on the same edge
  assign accept = load && (!valid || ready);
  assign drop   = load && valid && !ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data    <= '0;
      valid   <= 1'b0;
      perr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        data  <= load_data;
        perr  <= load_perr;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // a new drop wins over a simultaneous clear
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-to-parallel deserializer with valid/ready output
//
// Purpose: shifts qualified serial bits into N-bit words and hands each
//          completed word to a one-entry holding buffer.
// Ports:   clk, rst (async active-low)
//          s_data, shift_en, flush             - serial input side
//          p_data[N-1:0], p_valid, p_ready     - parallel output handshake
//          overrun, clr_overrun                - sticky dropped-word flag
//          parity_err                          - parity result of buffered word
// Config:  SIPO_DESER_PARITY_CHK_EN appends an even-parity bit to each frame;
//          without it parity_err is constant 0.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_data,
  input  logic         shift_en,
  input  logic         flush,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready,
  output logic         overrun,
  input  logic         clr_overrun,
  output logic         parity_err
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nxt;
  logic [N-1:0]   shreg, shreg_nxt, shifted;
  logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
  logic           load;
  logic [N-1:0]   load_data;
  logic           load_perr;
  logic           accept;

  always_comb begin
    if (MSB_FIRST) shifted = {shreg[N-2:0], s_data};
    else           shifted = {s_data, shreg[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    load        = 1'b0;
    load_data   = shifted;
    load_perr   = 1'b0;
    if (flush) begin
      // abort wins over a bit arriving on the same edge
      state_nxt   = COLLECT;
      shreg_nxt   = '0;
      bit_cnt_nxt = '0;
    end else if (shift_en) begin
      case (state)
        COLLECT: begin
          if (bit_cnt == CW'(N - 1)) begin
            bit_cnt_nxt = '0;
`ifdef SIPO_DESER_PARITY_CHK_EN
            // hold the data word until the parity bit arrives
            shreg_nxt = shifted;
            state_nxt = PARITY;
`else
            shreg_nxt = '0;
            load      = 1'b1;
            load_data = shifted;
`endif
          end else begin
            shreg_nxt   = shifted;
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          load      = 1'b1;
          load_data = shreg;
          load_perr = (^shreg) ^ s_data;
          shreg_nxt = '0;
          state_nxt = COLLECT;
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  sipo_out_buf #(.N(N)) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (load_data),
    .load_perr   (load_perr & PARITY_EN),
    .ready       (p_ready),
    .clr_overrun (clr_overrun),
    .data        (p_data),
    .valid       (p_valid),
    .perr        (parity_err),
    .overrun     (overrun),
    .accept      (accept)
  );

endmodule
